// File: rtl/div_radix2.sv
// div_radix2: iterative restoring divider for the EX-stage ALU.
// Produces one quotient bit per clock for DIV (signed) and DIVU (unsigned).
// result_o = {remainder, quotient}, i.e. {HI, LO}.
module div_radix2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     rem;      // partial remainder
    logic [DATA_W-1:0]     dvd;      // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]     div_abs;  // |divisor|
    logic                  q_neg;
    logic                  r_neg;

    // Combinational result of one restoring step
    logic [DATA_W:0]       shifted;
    logic [DATA_W:0]       diff;
    logic                  q_bit;
    logic [DATA_W-1:0]     rem_nxt;
    logic [DATA_W-1:0]     dvd_nxt;
    logic [DATA_W-1:0]     rem_fin;
    logic [DATA_W-1:0]     quo_fin;
    logic                  step_unused;

    // Two's-complement negation.
    function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    // Magnitude of an operand; only negative values in signed mode are flipped.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                              input logic           is_signed);
        return (is_signed && v[DATA_W-1]) ? neg2c(v) : v;
    endfunction

    // Sign correction applied once, as the last step completes.
    function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v,
                                                   input logic           neg);
        return neg ? neg2c(v) : v;
    endfunction

    // One restoring step. The shifted remainder keeps its top bit so that
    // divisors above 2^(DATA_W-1) still divide correctly; when the trial
    // subtraction succeeds the difference is below the divisor, so its top
    // bit is always zero and only the low DATA_W bits are kept.
    always_comb begin
        shifted     = {rem, dvd[DATA_W-1]};
        diff        = shifted - {1'b0, div_abs};
        q_bit       = (shifted >= {1'b0, div_abs});
        rem_nxt     = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        dvd_nxt     = {dvd[DATA_W-2:0], q_bit};
        rem_fin     = fix_sign(rem_nxt, r_neg);
        quo_fin     = fix_sign(dvd_nxt, q_neg);
        step_unused = diff[DATA_W];
    end

    // Divider FSM: operand capture, iteration, correction and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            div_abs  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_DIVZERO;
                        end else begin
                            div_abs <= mag(opdata2_i, signed_div_i);
                            dvd     <= mag(opdata1_i, signed_div_i);
                            rem     <= '0;
                            cnt     <= '0;
                            q_neg   <= signed_div_i &
                                       (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            r_neg   <= signed_div_i & opdata1_i[DATA_W-1];
                            state   <= S_ON;
                        end
                    end
                end

                S_DIVZERO: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem   <= '0;
                        dvd   <= '0;
                        state <= S_END;
                    end
                end

                S_ON: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            rem   <= rem_fin;
                            dvd   <= quo_fin;
                            state <= S_END;
                        end else begin
                            rem <= rem_nxt;
                            dvd <= dvd_nxt;
                        end
                    end
                end

                S_END: begin
                    if (annul_i || !start_i) begin
                        state    <= S_IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= {rem, dvd};
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: directed checks of the radix-2 divider.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks;
    int failures;

    div_radix2 #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a negedge. Holds start until ready, checks latency
    // (in edges after the start edge) and result, then optionally drops start.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int exp_lat,
                           input logic [63:0] exp_res, input bit drop,
                           input bit scramble, input string name);
        int lat;
        lat = -1;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (scramble && i == 5) begin
                opdata1    = 32'hDEAD_BEEF;
                opdata2    = 32'h0;
                signed_div = ~sgn;
            end
            if (ready) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %h expected %h", name, result, exp_res);
        end
        if (drop) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || result !== exp_res) begin
                failures++;
                $display("FAIL %s hold: ready=%b result=%h expected ready=1 result=%h",
                         name, ready, result, exp_res);
            end
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || result !== 64'h0) begin
                failures++;
                $display("FAIL %s release: ready=%b result=%h expected ready=0 result=0",
                         name, ready, result);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b result=%h expected ready=0 result=0",
                     ready, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        run_div(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b1, 1'b1, "udiv_100_7");
        run_div(32'hFFFF_FFFF, 32'h10, 1'b0, 33, {32'hF, 32'h0FFF_FFFF}, 1'b1, 1'b0, "udiv_max_16");
        run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 33, {32'h7FFF_FFFE, 32'h1}, 1'b1, 1'b0, "udiv_bigdiv");
        run_div(32'h0, 32'd5, 1'b0, 33, 64'h0, 1'b1, 1'b0, "udiv_zero_dividend");
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, 1'b0, "sdiv_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 33, {32'h1, 32'hFFFF_FFFD}, 1'b1, 1'b0, "sdiv_7_m2");
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 33, {32'hFFFF_FFFE, 32'd14}, 1'b1, 1'b0, "sdiv_m100_m7");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'h0, 32'h8000_0000}, 1'b1, 1'b0, "sdiv_min_m1");
        // Same operands in unsigned mode must not apply any correction.
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 33, {32'h1, 32'h7FFF_FFFC}, 1'b1, 1'b0, "udiv_fff9_2");
    endtask

    task automatic test_divzero();
        run_div(32'h1234, 32'h0, 1'b0, 2, 64'h0, 1'b1, 1'b0, "divzero");
    endtask

    task automatic test_annul();
        bit seen;
        // annul together with start in IDLE: the operation begins one edge later.
        opdata1    = 32'd9;
        opdata2    = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        annul      = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, 1'b1, 1'b0, "annul_idle");

        // annul during ON with start still requested: the aborted op never finishes.
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || result !== 64'h0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL annul_on: ready/result observed high=%b expected 0", seen);
        end
        // Flush the restarted request before the next operation.
        start = 1'b0;
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, 1'b1, 1'b0, "after_annul");
    endtask

    task automatic test_async_reset();
        // Mid-operation reset.
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        signed_div = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid_op: ready=%b result=%h expected ready=0 result=0",
                     ready, result);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b1, 1'b0, "after_rst");

        // Reset while a result is presented clears outputs without a clock edge.
        run_div(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b0, 1'b0, "pre_rst_end");
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            failures++;
            $display("FAIL rst_in_end: ready=%b result=%h expected ready=0 result=0",
                     ready, result);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, 1'b1, 1'b0, "after_rst_end");
    endtask

    task automatic test_back_to_back();
        run_div(32'd1000, 32'd10, 1'b0, 33, {32'd0, 32'd100}, 1'b1, 1'b0, "b2b_first");
        run_div(32'd1001, 32'd10, 1'b0, 33, {32'd1, 32'd100}, 1'b1, 1'b0, "b2b_second");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
